imem_dmem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb2_rr.sv | 53 +++++
 rtl/imem_dmem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//   arb_state_t     : arbiter FSM states
//   owner_t         : which requester owns the in-flight transaction
//   DEF_TIMEOUT_CYC : default response timeout, in cycles spent in RESP
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/arb2_rr.sv
// Two-way arbiter between the fetch port and the data port.
// Grant is combinational; the "last served" pointer is a register that
// moves only when the memory actually accepts a transaction.
//   clk, reset      : clock, asynchronous active-high reset
//   i_fetch_req     : fetch port is requesting
//   i_data_req      : data port is requesting
//   i_accept        : memory accepted the current transaction this cycle
//   i_accept_owner  : owner of the accepted transaction
//   o_any           : at least one port is requesting
//   o_winner        : port that would win if sampled now
module arb2_rr
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_fetch_req,
  input  logic   i_data_req,
  input  logic   i_accept,
  input  owner_t i_accept_owner,
  output logic   o_any,
  output owner_t o_winner
);

  owner_t r_last;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    o_any    = i_fetch_req | i_data_req;
    o_winner = OWN_D;
    if (i_fetch_req && i_data_req) begin
      // Ties: data always wins in priority mode, otherwise the port not
      // served last wins.
      o_winner = ((DATA_PRIO != 0) || (r_last == OWN_I)) ? OWN_D : OWN_I;
    end else if (i_fetch_req) begin
      o_winner = OWN_I;
    end
  end

  // Reset value OWN_I makes data win the first tie in round-robin mode.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= OWN_I;
    end else if (i_accept) begin
      r_last <= i_accept_owner;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port (proc_req / mem_ready / valid) between the fetch
// unit and the load/store unit. One winner is latched in IDLE, presented to
// memory in REQ until mem_ready, and its response is routed back in RESP.
// A fetch can be flushed (its response is dropped) and a missing response
// is aborted after TIMEOUT_CYC cycles with a bus_err pulse.
//   clk, reset                    : clock, asynchronous active-high reset
//   i_req/i_addr/i_flush          : fetch request, address, kill
//   i_gnt/i_rvalid/i_rdata        : fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be: data request and payload
//   d_gnt/d_rvalid/d_rdata        : data accept pulse, response pulse, data
//   bus_err                       : timeout abort pulse
//   proc_req/we/Add/Wdata/be      : request to memory
//   mem_ready/valid/Rdata         : memory accept, response valid and data
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int bits        = 32,
  parameter int DATA_PRIO   = 1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC  // must be >= 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [bits-1:0]     i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [bits-1:0]     i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [bits-1:0]     d_addr,
  input  logic [bits-1:0]     d_wdata,
  input  logic [bits/8-1:0]   d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [bits-1:0]     d_rdata,
  output logic                bus_err,
  output logic                proc_req,
  output logic                we,
  output logic [bits-1:0]     Add,
  output logic [bits-1:0]     Wdata,
  output logic [bits/8-1:0]   be,
  input  logic                mem_ready,
  input  logic                valid,
  input  logic [bits-1:0]     Rdata
);

  localparam int BE_W  = bits / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic [bits-1:0]   r_addr;
  logic [bits-1:0]   r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_we;
  logic              r_proc_req;
  logic              r_kill;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [bits-1:0]   r_i_rdata;
  logic [bits-1:0]   r_d_rdata;

  logic              w_any;
  owner_t            w_winner;
  logic              w_accept;
  logic              w_timeout;
  logic              w_flush_hit;

  arb2_rr #(
    .DATA_PRIO(DATA_PRIO)
  ) u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_fetch_req   (i_req),
    .i_data_req    (d_req),
    .i_accept      (w_accept),
    .i_accept_owner(r_owner),
    .o_any         (w_any),
    .o_winner      (w_winner)
  );

  assign w_accept    = (r_state == REQ) && mem_ready;
  // A valid in the last allowed cycle still wins over the abort.
  assign w_timeout   = (r_state == RESP) && !valid &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_flush_hit = i_flush && (r_owner == OWN_I) && (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_proc_req <= 1'b0;
      r_kill     <= 1'b0;
      r_cnt      <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_any) begin
            r_owner    <= w_winner;
            r_proc_req <= 1'b1;
            r_state    <= REQ;
            if (w_winner == OWN_D) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
              r_be    <= d_be;
            end else begin
              r_addr  <= i_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
              r_be    <= '1;
            end
          end
        end
        REQ: begin
          if (w_flush_hit) r_kill <= 1'b1;
          if (mem_ready) begin
            r_proc_req <= 1'b0;
            r_cnt      <= '0;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (w_flush_hit) r_kill <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (valid) begin
            r_state <= IDLE;
            if (r_owner == OWN_D) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= Rdata;
            end else if (!r_kill && !i_flush) begin
              // A flush arriving together with valid also drops the data.
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= Rdata;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_gnt    = w_accept && (r_owner == OWN_I);
  assign d_gnt    = w_accept && (r_owner == OWN_D);
  assign bus_err  = w_timeout;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign proc_req = r_proc_req;
  assign we       = r_we;
  assign Add      = r_addr;
  assign Wdata    = r_wdata;
  assign be       = r_be;

endmodule
